// File: rtl/cpu7_ifu_iqn_if.sv
// Fetch-return / decode-side bus of the IFU instruction queue.
// master = IFU/ICU side driving lines and control, slave = the queue itself.
interface cpu7_ifu_iqn_if #(
    parameter int INSTS = 2,
    parameter int OFS_W = 1,
    parameter int CNT_W = 3
);
    logic [32*INSTS-1:0] icu_ifu_data_ic2;
    logic                icu_ifu_data_valid_ic2;
    logic                exu_ifu_stall_req;
    logic                flush_iq;
    logic [OFS_W-1:0]    flush_ofs;
    logic [31:0]         inst_f;
    logic                inst_valid_f;
    logic                iq_not_empty;
    logic [CNT_W-1:0]    iq_count;
    logic                fetch_ahead;
    logic                iq_overflow;

    // Handshake: the queue offers inst_f whenever iq_not_empty; decode accepts
    // unless exu_ifu_stall_req, and inst_valid_f marks the cycle of transfer.
    // Fetch lines have no back-pressure; the IFU must honour fetch_ahead.
    modport master (
        output icu_ifu_data_ic2, icu_ifu_data_valid_ic2, exu_ifu_stall_req,
               flush_iq, flush_ofs,
        input  inst_f, inst_valid_f, iq_not_empty, iq_count, fetch_ahead,
               iq_overflow
    );

    modport slave (
        input  icu_ifu_data_ic2, icu_ifu_data_valid_ic2, exu_ifu_stall_req,
               flush_iq, flush_ofs,
        output inst_f, inst_valid_f, iq_not_empty, iq_count, fetch_ahead,
               iq_overflow
    );
endinterface

// File: rtl/cpu7_ifu_iqn.sv
// Multi-line instruction queue between ICU fetch return and the F stage:
// one instruction per cycle, same-cycle bypass when empty, post-flush start slot.
module cpu7_ifu_iqn #(
    parameter int DEPTH = 4,
    parameter int INSTS = 2,
    parameter int OFS_W = 1,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           resetn,
    cpu7_ifu_iqn_if.slave  iq
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [32*INSTS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [OFS_W-1:0]    slot;
    logic                overflow;

    logic                has_stored;
    logic                avail;
    logic                consume;
    logic                last_slot;
    logic                retire;
    logic                retire_mem;
    logic                bypass_retire;
    logic                full;
    logic                wr_req;
    logic                wr_en;
    logic                drop;
    logic [32*INSTS-1:0] head;
    logic [31:0]         head_slots [INSTS];
    logic [CNT_W-1:0]    count_next;

    always_comb begin
        has_stored = (count != '0);
        head       = has_stored ? mem[rd_ptr] : iq.icu_ifu_data_ic2;
        for (int k = 0; k < INSTS; k++) begin
            head_slots[k] = head[32*k +: 32];
        end
        // Reset gating keeps the decode handshake quiet while resetn is low.
        avail         = resetn & (has_stored | iq.icu_ifu_data_valid_ic2) & ~iq.flush_iq;
        consume       = avail & ~iq.exu_ifu_stall_req;
        last_slot     = (slot == OFS_W'(INSTS - 1));
        retire        = consume & last_slot;
        retire_mem    = retire & has_stored;
        bypass_retire = retire & ~has_stored;
        full          = (count == CNT_W'(DEPTH));
        // A bypassed line that is fully consumed on arrival never needs storing.
        wr_req        = iq.icu_ifu_data_valid_ic2 & ~iq.flush_iq & ~bypass_retire;
        wr_en         = wr_req & (~full | retire_mem);
        drop          = wr_req & full & ~retire_mem;
        count_next    = count + CNT_W'(wr_en) - CNT_W'(retire_mem);
    end

    assign iq.inst_f       = head_slots[slot];
    assign iq.inst_valid_f = consume;
    assign iq.iq_not_empty = avail;
    assign iq.iq_count     = count;
    assign iq.iq_overflow  = overflow;
    // One line of margin absorbs the request already in flight at the ICU.
    assign iq.fetch_ahead  = ~iq.flush_iq & ~iq.exu_ifu_stall_req &
                             (count_next < CNT_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            slot     <= '0;
            overflow <= 1'b0;
        end else begin
            if (iq.flush_iq) begin
                // The first line after a flush starts at the branch-target slot.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                slot   <= iq.flush_ofs;
            end else begin
                if (wr_en)      wr_ptr <= wr_ptr + PTR_W'(1);
                if (retire_mem) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_next;
                if (consume)    slot   <= last_slot ? '0 : slot + OFS_W'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= iq.icu_ifu_data_ic2;
    end
endmodule
